tt_um_hamming_encoder_7_4: RTL and testbench
============================================

// Module: tt_um_hamming_encoder_7_4
// PURPOSE
//  Upstream stage of the Hamming(7,4) decoder. Accepts 4-bit nibbles over a
//  valid/ready handshake and buffers them in a small FIFO. Encodes each nibble
//  to a 7-bit codeword and serializes it 1 bit per enabled cycle.
//  ser_out/ena drive the decoder's decode_in/ena directly.
// PARAMETERS
//  FIFO_DEPTH  4  nibble FIFO entries, power of 2, >=2
//  GAP_CYCLES  1  idle bit slots after each codeword (0..7); 1 => 8-slot frame
//  IDLE_LEVEL  0  ser_out value when idle / in gap slots
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  ena          in   1  downstream shift enable; state advances only when 1
//  in_valid     in   1  nibble offered
//  in_data      in   4  nibble {d1,d2,d3,d4} = in_data[3:0]
//  in_ready     out  1  FIFO can accept (registered from count)
//  ser_out      out  1  serial codeword bit (registered)
//  frame_start  out  1  high while ser_out carries codeword bit 1 (first)
//  busy         out  1  state != IDLE
//  fifo_count   out  clog2(FIFO_DEPTH)+1  entries held
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: FIFO emptied, state IDLE, ser_out=IDLE_LEVEL, frame_start=0, busy=0,
//   in_ready=1, fifo_count=0. Mid-frame reset abandons frame; no further bits.
//  Encode: p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4;
//   cw[6:0]={p1,p2,d1,p3,d2,d3,d4}; cw[6] (position 1) sent first.
//  FIFO: push when in_valid&in_ready. in_ready=(fifo_count<FIFO_DEPTH), with no
//   dependence on same-cycle pop; full+pop gives no push. No bypass: data
//   pushed in cycle N is poppable at N+1 earliest. Pointers wrap mod DEPTH.
//  FSM IDLE/SHIFT/GAP; bit_idx 0..6, gap_cnt 0..GAP_CYCLES-1. With ena=0,
//   all state, ser_out and frame_start hold (FIFO push still allowed).
//  IDLE: if ena & !empty -> pop, load cw; next cycle ser_out=cw[6],
//   frame_start=1, SHIFT, bit_idx=0.
//  SHIFT (ena): bit_idx<6 -> bit_idx++, ser_out=next bit, frame_start=0.
//   bit_idx==6: if GAP_CYCLES>0 -> GAP, ser_out=IDLE_LEVEL; else if !empty pop
//   and start next frame back-to-back (no idle slot); else IDLE.
//  GAP (ena): last gap slot -> if !empty pop and start next frame, else IDLE.
//  Latency: first bit 2 cycles after push into empty idle block (ena=1).
//  Frame period = 7+GAP_CYCLES enabled cycles while FIFO non-empty.
// CONFIGURATION
//  HAMMING_ENC_ERR_INJECT_EN defined: adds inputs err_inj_en(1), err_inj_pos(3),
//   sampled at pop; if err_inj_en and pos in 1..7, loaded codeword bit at
//   transmit position pos (1=first sent) is inverted; pos 0 = no flip.
//  Undefined: ports absent, codewords always exact.
// TESTING
//  Reset: rst=1 two cycles -> ser_out=0, busy=0, in_ready=1, fifo_count=0.
//  Push 4'b1011, ena=1 -> bits 0,1,1,0,0,1,1 then one 0 gap; frame_start once.
//  Push 0x0,0xF,0x5,0xA with ena=0 -> in_ready=0 at count 4; 5th push refused;
//   ena=1 -> 0000000,1111111,0100101,1011010 in 8-slot frames.
//  ena=0 for 3 cycles after 3rd bit of 1011 -> ser_out holds 1; resume intact.
//  rst=1 at 4th bit of a frame -> IDLE next cycle, FIFO empty, ser_out=0.
//  ERR_INJECT_EN: 1011, err_inj_en=1, pos=3 -> bits 0,1,0,0,0,1,1.

Source files
------------

// File: rtl/tt_um_hamming_encoder_7_4.sv
// Hamming(7,4) encoder front end: nibble FIFO, codeword encoder and 1-bit serializer.
// Defining HAMMING_ENC_ERR_INJECT_EN adds err_inj_en/err_inj_pos to flip one sent bit.
module tt_um_hamming_encoder_7_4 #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          in_valid,
    input  logic [3:0]                    in_data,
`ifdef HAMMING_ENC_ERR_INJECT_EN
    input  logic                          err_inj_en,
    input  logic [2:0]                    err_inj_pos,
`endif
    output logic                          in_ready,
    output logic                          ser_out,
    output logic                          frame_start,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam bit NO_GAP = (GAP_CYCLES == 0);
    localparam logic [2:0] GAP_LAST = 3'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

    state_e         state_q;
    logic [2:0]     bit_idx_q;
    logic [2:0]     gap_cnt_q;
    logic [5:0]     sr_q;
    logic           ser_out_q;
    logic           frame_start_q;

    logic [3:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           in_ready_q;

    logic           push;
    logic           pop;
    logic           empty;
    logic [3:0]     head;
    logic [6:0]     inj_mask;
    logic [6:0]     cw_load;

    function automatic logic [6:0] encode(input logic [3:0] nib);
        logic d1, d2, d3, d4;
        {d1, d2, d3, d4} = nib;
        return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    endfunction

`ifdef HAMMING_ENC_ERR_INJECT_EN
    // Position 1 is the first bit on the wire, i.e. codeword bit 6.
    always_comb begin
        inj_mask = '0;
        if (err_inj_en && (err_inj_pos != 3'd0)) begin
            inj_mask = 7'b1000000 >> (err_inj_pos - 3'd1);
        end
    end
`else
    assign inj_mask = '0;
`endif

    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign cw_load = encode(head) ^ inj_mask;
    assign push    = in_valid && in_ready_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_comb begin
        pop = 1'b0;
        if (ena && !empty) begin
            case (state_q)
                IDLE:    pop = 1'b1;
                SHIFT:   pop = NO_GAP && (bit_idx_q == 3'd6);
                GAP:     pop = (gap_cnt_q == GAP_LAST);
                default: pop = 1'b0;
            endcase
        end
    end

    // in_ready is registered from the next count, so a full FIFO refuses a push even while popping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            in_ready_q <= (count_d < DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            gap_cnt_q     <= '0;
            sr_q          <= '0;
            ser_out_q     <= IDLE_LEVEL;
            frame_start_q <= 1'b0;
        end else if (ena) begin
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q       <= SHIFT;
                        bit_idx_q     <= '0;
                        ser_out_q     <= cw_load[6];
                        sr_q          <= cw_load[5:0];
                        frame_start_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_idx_q != 3'd6) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        ser_out_q <= sr_q[5];
                        sr_q      <= {sr_q[4:0], 1'b0};
                    end else if (!NO_GAP) begin
                        state_q   <= GAP;
                        gap_cnt_q <= '0;
                        ser_out_q <= IDLE_LEVEL;
                    end else if (pop) begin
                        bit_idx_q     <= '0;
                        ser_out_q     <= cw_load[6];
                        sr_q          <= cw_load[5:0];
                        frame_start_q <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                        ser_out_q <= IDLE_LEVEL;
                    end
                end
                GAP: begin
                    if (gap_cnt_q != GAP_LAST) begin
                        gap_cnt_q <= gap_cnt_q + 3'd1;
                    end else if (pop) begin
                        state_q       <= SHIFT;
                        bit_idx_q     <= '0;
                        ser_out_q     <= cw_load[6];
                        sr_q          <= cw_load[5:0];
                        frame_start_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign ser_out     = ser_out_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != IDLE);
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_tt_um_hamming_encoder_7_4.sv
// Self-checking bench for tt_um_hamming_encoder_7_4 (default parameters).
// Exercises the HAMMING_ENC_ERR_INJECT_EN ports too when that macro is defined.
module tb_tt_um_hamming_encoder_7_4;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] cw;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic       inValid = 1'b0;
    logic [3:0] inData = '0;
    logic       inReady;
    logic       serOut;
    logic       frameStart;
    logic       busy;
    logic [2:0] fifoCount;
`ifdef HAMMING_ENC_ERR_INJECT_EN
    logic       errInjEn = 1'b0;
    logic [2:0] errInjPos = '0;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    logic [6:0] expQ [$];
    vec_t vectors [16];

    tt_um_hamming_encoder_7_4 dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .in_valid    (inValid),
        .in_data     (inData),
`ifdef HAMMING_ENC_ERR_INJECT_EN
        .err_inj_en  (errInjEn),
        .err_inj_pos (errInjPos),
`endif
        .in_ready    (inReady),
        .ser_out     (serOut),
        .frame_start (frameStart),
        .busy        (busy),
        .fifo_count  (fifoCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change one time unit after the edge; the push lands on the following edge.
    task automatic applyStimulus(input logic [3:0] nib, input logic [6:0] expCw);
        int guard = 0;
        while (!inReady && guard < 50) begin
            step();
            guard++;
        end
        inValid = 1'b1;
        inData  = nib;
        step();
        inValid = 1'b0;
        expQ.push_back(expCw);
    endtask

    task automatic waitFrameStart(output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!frameStart && waited < 60);
    endtask

    task automatic checkFrame(input string tag, output int waited);
        logic [6:0] exp;
        logic [6:0] got;
        int starts;
        waitFrameStart(waited);
        checkOutput({tag, " frame_start"}, int'(frameStart), 1);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 7'h7f;
        checkOutput({tag, " scoreboard entry"}, (expQ.size() >= 0) ? 1 : 0, 1);
        got = '0;
        starts = 0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            got[6 - i] = serOut;
            starts += int'(frameStart);
        end
        checkOutput({tag, " codeword"}, int'(got), int'(exp));
        checkOutput({tag, " frame_start pulses"}, starts, 1);
        step();
        checkOutput({tag, " gap level"}, int'(serOut), 0);
        checkOutput({tag, " gap frame_start"}, int'(frameStart), 0);
    endtask

    initial begin
        int waited;
        int starts;
        logic [3:0] tail;

        vectors = '{
            '{4'h0, 7'b0000000}, '{4'h1, 7'b1101001}, '{4'h2, 7'b0101010}, '{4'h3, 7'b1000011},
            '{4'h4, 7'b1001100}, '{4'h5, 7'b0100101}, '{4'h6, 7'b1100110}, '{4'h7, 7'b0001111},
            '{4'h8, 7'b1110000}, '{4'h9, 7'b0011001}, '{4'hA, 7'b1011010}, '{4'hB, 7'b0110011},
            '{4'hC, 7'b0111100}, '{4'hD, 7'b1010101}, '{4'hE, 7'b0010110}, '{4'hF, 7'b1111111}
        };

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkOutput("reset ser_out", int'(serOut), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset in_ready", int'(inReady), 1);
        checkOutput("reset fifo_count", int'(fifoCount), 0);
        checkOutput("reset frame_start", int'(frameStart), 0);

        // Single 1011 frame, including the one-edge pop latency after the push.
        ena = 1'b1;
        applyStimulus(4'hB, 7'b0110011);
        checkFrame("single 1011", waited);
        checkOutput("first bit latency", waited, 1);
        step();
        checkOutput("idle after frame busy", int'(busy), 0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vectors[i].nib, vectors[i].cw);
            checkFrame($sformatf("vector %0h", vectors[i].nib), waited);
        end

        // Fill the FIFO while the serializer is stalled, then drain back-to-back.
        step();
        ena = 1'b0;
        applyStimulus(4'h0, 7'b0000000);
        applyStimulus(4'hF, 7'b1111111);
        applyStimulus(4'h5, 7'b0100101);
        checkOutput("count at 3 in_ready", int'(inReady), 1);
        applyStimulus(4'hA, 7'b1011010);
        checkOutput("full fifo_count", int'(fifoCount), 4);
        checkOutput("full in_ready", int'(inReady), 0);
        inValid = 1'b1;
        inData  = 4'h3;
        step();
        inValid = 1'b0;
        checkOutput("refused push fifo_count", int'(fifoCount), 4);
        checkOutput("stalled busy", int'(busy), 0);
        ena = 1'b1;
        for (int f = 0; f < 4; f++) begin
            checkFrame($sformatf("burst frame %0d", f), waited);
            checkOutput($sformatf("burst spacing %0d", f), waited, 1);
        end
        step();
        checkOutput("burst drained fifo_count", int'(fifoCount), 0);

        // Stall for three cycles after the third bit of 1011.
        applyStimulus(4'hB, 7'b0110011);
        waitFrameStart(waited);
        void'(expQ.pop_front());
        step();
        step();
        checkOutput("hold third bit", int'(serOut), 1);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("hold cycle %0d ser_out", i), int'(serOut), 1);
        end
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tail[3 - i] = serOut;
        end
        checkOutput("resumed tail bits", int'(tail), 4'b0011);
        step();
        checkOutput("resumed gap", int'(serOut), 0);

        // Reset in the fourth bit slot with a second nibble still queued.
        step();
        ena = 1'b0;
        applyStimulus(4'hB, 7'b0110011);
        applyStimulus(4'h5, 7'b0100101);
        ena = 1'b1;
        waitFrameStart(waited);
        step();
        step();
        step();
        checkOutput("pre-reset fifo_count", int'(fifoCount), 1);
        checkOutput("pre-reset busy", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mid reset busy", int'(busy), 0);
        checkOutput("mid reset fifo_count", int'(fifoCount), 0);
        checkOutput("mid reset ser_out", int'(serOut), 0);
        checkOutput("mid reset in_ready", int'(inReady), 1);
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            starts += int'(frameStart) + int'(busy);
        end
        checkOutput("no frame after reset", starts, 0);
        expQ.delete();

`ifdef HAMMING_ENC_ERR_INJECT_EN
        errInjEn  = 1'b1;
        errInjPos = 3'd3;
        applyStimulus(4'hB, 7'b0100011);
        checkFrame("inject pos 3", waited);
        errInjEn  = 1'b0;
        errInjPos = 3'd0;
        applyStimulus(4'hB, 7'b0110011);
        checkFrame("inject off", waited);
`endif

        checkOutput("scoreboard empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
